// File: rtl/day11_serial_comparator_if.sv
// Operand/result bundle for the bit-serial magnitude comparator.
// The master issues start with operands; the slave reports busy, done and a one-hot g/e/s result.
interface day11_serial_comparator_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             g;
    logic             e;
    logic             s;

    modport master (
        output start, a, b,
        input  busy, done, g, e, s
    );

    modport slave (
        input  start, a, b,
        output busy, done, g, e, s
    );
endinterface

// File: rtl/day11_serial_comparator.sv
// Bit-serial unsigned magnitude comparator: walks captured operands two bits per clock,
// MSB pair first, stopping on the first unequal pair and reporting a one-hot g/e/s result.
module day11_serial_comparator #(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst,
    day11_serial_comparator_if.slave bus
);
    localparam int P  = WIDTH / 2;
    localparam int IW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_g;
    logic             r_e;
    logic             r_s;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [IW-1:0]    w_idx_nxt;
    logic             w_g_nxt;
    logic             w_e_nxt;
    logic             w_s_nxt;
    logic [1:0]       w_pa;
    logic [1:0]       w_pb;
    logic             w_last;

    // Cascaded 2-bit rule: the high bit decides unless it ties, then the low bit decides.
    function automatic logic pair_gt(input logic [1:0] x, input logic [1:0] y);
        return (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
    endfunction

    function automatic logic pair_lt(input logic [1:0] x, input logic [1:0] y);
        return (~x[1] & y[1]) | (~(x[1] ^ y[1]) & ~x[0] & y[0]);
    endfunction

    assign w_pa   = r_a[(WIDTH - 1) - 2 * int'(r_idx) -: 2];
    assign w_pb   = r_b[(WIDTH - 1) - 2 * int'(r_idx) -: 2];
    assign w_last = (r_idx == IW'(P - 1));

    // Next-state and next-register computation for the pair-stepping FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_g_nxt     = r_g;
        w_e_nxt     = r_e;
        w_s_nxt     = r_s;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_a_nxt     = bus.a;
                    w_b_nxt     = bus.b;
                    w_idx_nxt   = '0;
                    w_g_nxt     = 1'b0;
                    w_e_nxt     = 1'b0;
                    w_s_nxt     = 1'b0;
                    w_state_nxt = ST_RUN;
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pair_gt(w_pa, w_pb)) begin
                    w_g_nxt     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (pair_lt(w_pa, w_pb)) begin
                    w_s_nxt     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_last) begin
                    w_e_nxt     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt   = r_idx + IW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_s     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_g     <= w_g_nxt;
            r_e     <= w_e_nxt;
            r_s     <= w_s_nxt;
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.g    = r_g;
    assign bus.e    = r_e;
    assign bus.s    = r_s;
endmodule

// File: tb/tb_day11_serial_comparator.sv
// Scoreboard bench for day11_serial_comparator: the driver pushes expected result and done cycle,
// an independent monitor checks every cycle's busy/done/g/e/s against the queue head.
module tb_day11_serial_comparator;
    localparam int W = 8;
    localparam int P = W / 2;

    typedef struct {
        logic [2:0] res;     // {g,e,s}
        int         t_start;
        int         t_done;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    logic mon_en;
    logic [2:0] last_res;
    exp_t sb[$];

    day11_serial_comparator_if #(.WIDTH(W)) bus ();

    day11_serial_comparator #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Reference: plain unsigned comparison, latency from position of first differing pair.
    function automatic logic [2:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x > y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int k = 0; k < P; k++) begin
            if (((x >> (W - 2 - 2 * k)) & 3) != ((y >> (W - 2 - 2 * k)) & 3)) return k + 2;
        end
        return P + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        exp_t x;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        x.res     = model_res(ta, tb_v);
        x.t_start = cyc;
        x.t_done  = cyc + model_lat(ta, tb_v);
        sb.push_back(x);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < P + 4) begin
            tick();
            n++;
        end
        if (bus.done !== 1'b1) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL done_timeout at cycle %0d: got no done expected done", cyc);
        end
    endtask

    // Monitor: every cycle, compare DUT outputs against the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            logic exp_busy;
            exp_busy = (sb.size() > 0) && (cyc > sb[0].t_start) && (cyc < sb[0].t_done);
            check("busy", int'(bus.busy), int'(exp_busy));
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("done_cycle", cyc, x.t_done);
                    check("result_ges", int'({bus.g, bus.e, bus.s}), int'(x.res));
                    last_res = x.res;
                end
            end else if (bus.busy === 1'b1) begin
                check("ges_clear_while_busy", int'({bus.g, bus.e, bus.s}), 0);
            end else begin
                check("ges_hold", int'({bus.g, bus.e, bus.s}), int'(last_res));
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        cyc       = 0;
        n_cmp     = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        last_res  = 3'b000;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        check("reset_outputs", int'({bus.busy, bus.done, bus.g, bus.e, bus.s}), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Equal operands: done+e at T+5, e held afterwards.
        issue(8'hA5, 8'hA5); tick(); bus.start = 1'b0;
        wait_done(); tick(); tick();

        // Early greater at MSB pair.
        issue(8'hC0, 8'h40); tick(); bus.start = 1'b0;
        wait_done(); tick();

        // Late smaller; operands change right after capture.
        issue(8'h12, 8'h13); tick(); bus.start = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
        wait_done(); tick();

        // Start while busy is ignored.
        issue(8'h00, 8'h00); tick(); bus.start = 1'b0; tick();
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00; tick(); bus.start = 1'b0;
        wait_done(); tick();

        // Reset mid-run, then a fresh comparison.
        issue(8'h55, 8'h55); tick(); bus.start = 1'b0; tick();
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        last_res = 3'b000;
        tick();
        check("mid_reset_outputs", int'({bus.busy, bus.done, bus.g, bus.e, bus.s}), 0);
        rst = 1'b0;
        tick();
        issue(8'h01, 8'h02); tick(); bus.start = 1'b0;
        wait_done(); tick();

        // Back-to-back: new start in the DONE cycle.
        issue(8'h80, 8'h00); tick(); bus.start = 1'b0;
        wait_done();
        issue(8'h00, 8'h80); tick(); bus.start = 1'b0;
        wait_done(); tick();

        // Randomized comparisons with shared prefixes, spurious starts and back-to-back issue.
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0: rb = W'($urandom);
                1: rb = ra;
                default: rb = ra ^ (W'($urandom_range(1, 3)) << (2 * $urandom_range(0, P - 1)));
            endcase
            issue(ra, rb);
            tick();
            if ($urandom_range(0, 1) == 1) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                tick();
            end
            bus.start = 1'b0;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            wait_done();
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) tick();
            end
        end

        tick(); tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/day11_serial_comparator.md
# day11_serial_comparator

Bit-serial magnitude comparator for WIDTH-bit unsigned operands. It captures both operands on a start pulse, then walks them two bits per cycle, MSB pair first, applying the team's cascaded 2-bit greater/equal/smaller rule. It terminates early on the first unequal pair and reports a one-hot g/e/s result with a done pulse. It sits downstream of the 2-bit comparator stage and extends that stage's combinational pair result to arbitrary even widths at one pair per clock.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 2. Pair count is P = WIDTH/2.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request a comparison; accepted only when busy = 0.
- a  input  WIDTH  operand A (unsigned); sampled only on an accepted start.
- b  input  WIDTH  operand B (unsigned); sampled only on an accepted start.
- busy  output  1  high while the block is stepping pairs (RUN state).
- done  output  1  one-cycle pulse; g/e/s are valid from this cycle onward.
- g  output  1  result A > B.
- e  output  1  result A == B.
- s  output  1  result A < B.

## Operation
- States:
  - IDLE: reset state.
  - RUN: stepping pairs.
  - DONE: one-cycle result-announce state.
- Internal registers:
  - a_r, b_r: operand copies, WIDTH bits each.
  - idx: pair index, max($clog2(P),1) bits; pair k is bits [WIDTH-1-2k : WIDTH-2-2k].
  - res_g, res_e, res_s: result flags driving g/e/s.
- IDLE/DONE + start:
  - Load a_r ← a and b_r ← b.
  - Set idx ← 0 and clear g/e/s to 0.
  - Go to RUN.
- IDLE, no start: hold.
- DONE, no start: go to IDLE and keep g/e/s.
- RUN, each cycle, pair k = idx is compared with the 2-bit rule (gt = a1&~b1 | ~(a1^b1)&a0&~b0, analogous for lt):
  - pair gt → res_g ← 1, go to DONE.
  - pair lt → res_s ← 1, go to DONE.
  - pair equal and idx == P-1 → res_e ← 1, go to DONE.
  - pair equal and idx < P-1 → idx ← idx+1, stay in RUN.
- Output decode:
  - busy = (state == RUN).
  - done = (state == DONE).
- g/e/s hold their last result until the next accepted start or reset. After any done they are exactly one-hot.
- start while in RUN is ignored. It does not restart the comparison and does not modify a_r/b_r.
- Inputs a/b may change freely after the start cycle; the comparison uses only the captured copies.
- Reset in any state, including mid-RUN:
  - Abandons the comparison.
  - Next cycle: state = IDLE, busy = done = g = e = s = 0, idx = 0.
- rst and start in the same cycle: rst wins and start is dropped.

## Timing
- Reset values: busy 0, done 0, g 0, e 0, s 0.
- Accepted start in cycle T:
  - busy = 1 from T+1.
  - Pair k is evaluated in cycle T+1+k.
- First unequal pair at index k: done = 1 and g or s = 1 in cycle T+2+k; busy = 0 in that cycle.
- Full equality: done and e = 1 in cycle T+1+P. For WIDTH = 8 that is T+5.
- Minimum latency (start to done) is 2 cycles; maximum is P+1 cycles.
- g/e/s read 0 in cycles T+1 … (done cycle − 1) after an accepted start.
- Back-to-back: start asserted in the DONE cycle D is accepted.
  - busy = 1 at D+1.
  - g/e/s clear at D+1.
  - done is not re-pulsed until the new result.
- Throughput: one comparison per (k+2) cycles when starts are issued on each done.

## Test plan
- Equal operands: WIDTH=8, a=8'hA5, b=8'hA5, start at T.
  - busy high T+1..T+4.
  - done=1, e=1, g=s=0 at T+5.
  - done=0 at T+6 with e held.
- Early greater: a=8'hC0, b=8'h40 (MSB pair 11 vs 01), start at T.
  - done=1, g=1 at T+2.
  - busy high only at T+1.
- Late smaller: a=8'h12, b=8'h13 (differ at pair 3), start at T.
  - done=1, s=1 at T+5.
  - a/b changed to 8'hFF at T+1 without affecting the result.
- Start while busy: start a=8'h00, b=8'h00 at T, then start a=8'hFF, b=8'h00 at T+2.
  - Second start ignored.
  - done, e=1 at T+5.
  - No g at any point.
- Reset mid-run: start a=8'h55, b=8'h55 at T, rst=1 at T+2.
  - At T+3 all outputs 0 and state IDLE.
  - New start at T+4 with a=8'h01, b=8'h02 gives s=1 at T+9.
- Back-to-back: result done at D from a=8'h80, b=8'h00 (g=1); start a=8'h00, b=8'h80 at D.
  - g cleared and busy=1 at D+1.
  - done, s=1 at D+2.
